issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameters: NUM_REG, default 8, register count; LOAD_LAT, default 2, load latency; MUL_LAT, default 3, MUL latency; DIV_LAT, default 6, DIV latency. ALU-op latency fixed at 1; all latencies >= 1.
REQ-002 SHALL derive REG_SELECT = $clog2(NUM_REG) and D = max(1, LOAD_LAT, MUL_LAT, DIV_LAT).
REQ-003 clk  in  1  rising-edge clock; the block's only clock.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_valid  in  1  decoded instruction present.
REQ-006 i_rd, i_rs1, i_rs2  in  REG_SELECT each  destination and source selects.
REQ-007 i_uses_rs2  in  1  rs2 is a real operand.
REQ-008 i_is_write, i_is_load  in  1 each  decoder write and load flags.
REQ-009 i_alu_op  in  alu_op_e  operation; MUL and DIV select their latencies.
REQ-010 i_flush  in  1  suppress issue this cycle.
REQ-011 o_issue  out  1  instruction accepted this cycle (combinational).
REQ-012 o_stall  out  1  i_valid & ~i_flush & ~o_issue.
REQ-013 o_wb_valid, o_wb_sel  out  1, REG_SELECT  registered writeback strobe and register.
REQ-014 o_div_busy  out  1  divider occupied.
REQ-015 o_stall_count  out  16  saturating stall-cycle counter.

Function
REQ-016 Latency L SHALL be: LOAD_LAT if i_is_load; else MUL_LAT for MUL, DIV_LAT for DIV; else 1.
REQ-017 SHALL keep pending[NUM_REG], one bit per register with an outstanding write.
REQ-018 SHALL keep a writeback slot array wb_slot[0..D-1], each {valid, sel}; o_wb_valid/o_wb_sel = wb_slot[0].
REQ-019 Each cycle SHALL shift wb_slot[k] <= wb_slot[k+1]; wb_slot[D-1] <= empty unless written by issue.
REQ-020 Clear mask C = one-hot(o_wb_sel) when o_wb_valid, else 0; effective pending P = pending & ~C (same-cycle bypass).
REQ-021 o_issue SHALL be i_valid & ~i_flush & ~P[i_rs1] & ~(i_uses_rs2 & P[i_rs2]) & ~(i_is_write & P[i_rd]) & slot_free & div_free.
REQ-022 slot_free SHALL be 1 when ~i_is_write, or L = D, or ~wb_slot[L].valid.
REQ-023 div_free SHALL be 1 unless the op is DIV and div counter != 0.
REQ-024 On issue with i_is_write SHALL set pending[i_rd] and write wb_slot[L-1] <= {1, i_rd}; o_wb_valid for it exactly L cycles after issue.
REQ-025 Simultaneous clear and set of the same register SHALL leave pending set.
REQ-026 Issue with i_is_write = 0 (store, branch, unrecognised opcode) SHALL reserve no slot and set no pending bit; RAW checks still apply.
REQ-027 Div counter SHALL load DIV_LAT-1 on DIV issue, decrement to 0 and hold; o_div_busy = counter != 0.
REQ-028 i_flush SHALL block only the current issue; in-flight writebacks complete unchanged.
REQ-029 o_stall_count SHALL increment on each o_stall cycle and saturate at 16'hFFFF.
REQ-030 Unused i_rs2 (i_uses_rs2 = 0) SHALL never cause a stall.

Reset
REQ-031 While rst_n = 0 SHALL immediately force: pending = 0, all wb_slot invalid, o_wb_valid = 0, o_wb_sel = 0, div counter = 0, o_div_busy = 0, o_stall_count = 0.
REQ-032 Reset mid-operation SHALL drop all in-flight writebacks without emitting them; first edge after release behaves as idle.

Verification
REQ-033 ADD rd=1 at cycle 0 -> o_wb_valid=1, o_wb_sel=1 at cycle 1; ADD rs1=1 presented cycle 1 -> o_issue=1 at cycle 1 (bypass).
REQ-034 LW rd=2 at cycle 0; ADD rs1=2 presented cycle 1 -> o_stall=1 at cycle 1, o_issue=1 at cycle 2, o_stall_count=1.
REQ-035 MUL rd=3 at cycle 0; independent ADD rd=4 presented cycle 2 -> stall (slot conflict), issue cycle 3, wb r3 at cycle 3, r4 at cycle 4.
REQ-036 DIV rd=5 at cycle 0; DIV rd=6 presented cycle 1 -> o_div_busy cycles 1-5, second DIV issues cycle 6, r5 wb cycle 6, r6 wb cycle 12.
REQ-037 MUL rd=3 at cycle 0, rst_n low at cycle 1 -> o_wb_valid=0 immediately and at cycle 3; after release ADD rs1=3 issues with no stall.
REQ-038 i_flush=1 with valid ADD -> o_issue=0, o_stall=0, no writeback; 70000 consecutive stall cycles -> o_stall_count=16'hFFFF.

Source files
------------

// File: rtl/issue_ctrl_if.sv
// Issue-control operation encoding and the decoder <-> issue_ctrl bundle.
//
// issue_ctrl_pkg : alu_op_e, the operation field carried with each
//                  decoded instruction (MUL/DIV select long latencies).
// issue_ctrl_if  : decoded instruction, flush, issue/stall response,
//                  writeback strobe, divider busy and stall counter.
//   master - decoder side (drives i_*, observes o_*)
//   slave  - issue_ctrl side

package issue_ctrl_pkg;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_MUL = 3'd6,
        OP_DIV = 3'd7
    } alu_op_e;
endpackage

interface issue_ctrl_if
    import issue_ctrl_pkg::*;
#(
    parameter int NUM_REG = 8
);
    localparam int REG_SELECT = $clog2(NUM_REG);

    logic                  i_valid;
    logic [REG_SELECT-1:0] i_rd;
    logic [REG_SELECT-1:0] i_rs1;
    logic [REG_SELECT-1:0] i_rs2;
    logic                  i_uses_rs2;
    logic                  i_is_write;
    logic                  i_is_load;
    alu_op_e               i_alu_op;
    logic                  i_flush;

    logic                  o_issue;
    logic                  o_stall;
    logic                  o_wb_valid;
    logic [REG_SELECT-1:0] o_wb_sel;
    logic                  o_div_busy;
    logic [15:0]           o_stall_count;

    modport master (
        output i_valid, i_rd, i_rs1, i_rs2, i_uses_rs2, i_is_write,
               i_is_load, i_alu_op, i_flush,
        input  o_issue, o_stall, o_wb_valid, o_wb_sel, o_div_busy,
               o_stall_count
    );

    modport slave (
        input  i_valid, i_rd, i_rs1, i_rs2, i_uses_rs2, i_is_write,
               i_is_load, i_alu_op, i_flush,
        output o_issue, o_stall, o_wb_valid, o_wb_sel, o_div_busy,
               o_stall_count
    );
endinterface

// File: rtl/issue_ctrl.sv
// In-order issue controller with register scoreboard and writeback-slot
// reservation.
//
// Each write-issuing instruction marks its destination pending and books
// the writeback slot L-1 cycles ahead (L = its latency), so writebacks
// never collide on the single register-file write port. The slot at the
// head of the array is the registered writeback strobe; its register is
// released from the scoreboard in the same cycle (bypass), letting a
// dependent instruction issue on the writeback cycle.
//
// Ports
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - issue_ctrl_if.slave: decoded instruction in, issue/stall,
//            writeback strobe/select, divider busy, stall counter out
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int NUM_REG  = 8,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    issue_ctrl_if.slave  bus
);
    localparam int REG_SELECT = $clog2(NUM_REG);
    localparam int D0 = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
    localparam int D1 = (D0 > DIV_LAT) ? D0 : DIV_LAT;
    localparam int D  = (D1 > 1) ? D1 : 1;
    localparam int LW  = $clog2(D + 1);
    localparam int DCW = $clog2(DIV_LAT + 1);

    typedef struct packed {
        logic                  valid;
        logic [REG_SELECT-1:0] sel;
    } wb_slot_t;

    wb_slot_t [D-1:0]     wb_slot, wb_slot_n;
    logic [NUM_REG-1:0]   pending, pending_n;
    logic [NUM_REG-1:0]   clr_mask, pend_eff;
    logic [DCW-1:0]       div_cnt, div_cnt_n;
    logic [15:0]          stall_cnt, stall_cnt_n;

    logic [LW-1:0]        lat;
    logic                 is_div;
    logic                 slot_busy;
    logic                 slot_free;
    logic                 div_free;
    logic                 raw_hit;
    logic                 issue;
    logic                 stall;

    // Latency selection: a load's latency wins over the opcode.
    always_comb begin
        lat = LW'(1);
        if (bus.i_is_load)
            lat = LW'(LOAD_LAT);
        else if (bus.i_alu_op == OP_MUL)
            lat = LW'(MUL_LAT);
        else if (bus.i_alu_op == OP_DIV)
            lat = LW'(DIV_LAT);
    end

    assign is_div = (bus.i_alu_op == OP_DIV);

    // The slot at index L shifts into L-1 this edge, exactly where the new
    // writeback would land. L = D has no occupant to collide with.
    always_comb begin
        slot_busy = 1'b0;
        for (int k = 1; k < D; k++) begin
            if (int'(lat) == k)
                slot_busy = wb_slot[k].valid;
        end
    end

    assign slot_free = ~bus.i_is_write | ~slot_busy;
    assign div_free  = ~is_div | (div_cnt == '0);

    // Writeback in progress frees its register for this cycle's checks.
    assign clr_mask = wb_slot[0].valid ? (NUM_REG'(1) << wb_slot[0].sel) : '0;
    assign pend_eff = pending & ~clr_mask;

    assign raw_hit = pend_eff[bus.i_rs1]
                   | (bus.i_uses_rs2 & pend_eff[bus.i_rs2])
                   | (bus.i_is_write & pend_eff[bus.i_rd]);

    assign issue = bus.i_valid & ~bus.i_flush & ~raw_hit & slot_free & div_free;
    assign stall = bus.i_valid & ~bus.i_flush & ~issue;

    always_comb begin
        wb_slot_n = '0;
        for (int k = 0; k < D - 1; k++)
            wb_slot_n[k] = wb_slot[k + 1];

        pending_n = pend_eff;

        if (issue && bus.i_is_write) begin
            // Set after clear: a register retiring and re-issuing in the
            // same cycle stays pending for the new writer.
            pending_n[bus.i_rd] = 1'b1;
            for (int k = 0; k < D; k++) begin
                if (int'(lat) - 1 == k) begin
                    wb_slot_n[k].valid = 1'b1;
                    wb_slot_n[k].sel   = bus.i_rd;
                end
            end
        end

        div_cnt_n = div_cnt;
        if (issue && is_div)
            div_cnt_n = DCW'(DIV_LAT - 1);
        else if (div_cnt != '0)
            div_cnt_n = div_cnt - 1'b1;

        stall_cnt_n = stall_cnt;
        if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt_n = stall_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_slot   <= '0;
            pending   <= '0;
            div_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            wb_slot   <= wb_slot_n;
            pending   <= pending_n;
            div_cnt   <= div_cnt_n;
            stall_cnt <= stall_cnt_n;
        end
    end

    assign bus.o_issue       = issue;
    assign bus.o_stall       = stall;
    assign bus.o_wb_valid    = wb_slot[0].valid;
    assign bus.o_wb_sel      = wb_slot[0].sel;
    assign bus.o_div_busy    = (div_cnt != '0);
    assign bus.o_stall_count = stall_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl at default parameters
// (NUM_REG 8, LOAD 2, MUL 3, DIV 6 -> D = 6).
// Inputs change 1 time unit after a rising edge; outputs are sampled on
// the falling edge. "Cycle n" is the interval after the n-th rising edge
// of a scenario.
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    localparam int NREG = 8;
    localparam int RS   = $clog2(NREG);

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    issue_ctrl_if #(.NUM_REG(NREG)) bus ();

    issue_ctrl #(
        .NUM_REG (NREG),
        .LOAD_LAT(2),
        .MUL_LAT (3),
        .DIV_LAT (6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input int rd, input int rs1, input int rs2,
                       input logic u2, input logic wr, input logic ld,
                       input alu_op_e op, input logic fl);
        bus.i_valid    = v;
        bus.i_rd       = RS'(rd);
        bus.i_rs1      = RS'(rs1);
        bus.i_rs2      = RS'(rs2);
        bus.i_uses_rs2 = u2;
        bus.i_is_write = wr;
        bus.i_is_load  = ld;
        bus.i_alu_op   = op;
        bus.i_flush    = fl;
    endtask

    task automatic idle();
        drv(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, OP_ADD, 1'b0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Assert reset, confirm outputs clear without waiting for an edge,
    // hold for two edges, release just after an edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        idle();
        #1;
        chk({tag, "_rst_wbv"}, 32'(bus.o_wb_valid), 32'd0);
        chk({tag, "_rst_wbs"}, 32'(bus.o_wb_sel), 32'd0);
        chk({tag, "_rst_busy"}, 32'(bus.o_div_busy), 32'd0);
        chk({tag, "_rst_cnt"}, 32'(bus.o_stall_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle();

        // ---- power-on reset state
        do_reset("por");

        // ---- ADD->ADD bypass on the writeback cycle
        drv(1, 1, 0, 0, 1, 1, 0, OP_ADD, 0);
        smp(); chk("byp_c0_issue", 32'(bus.o_issue), 32'd1);
               chk("byp_c0_stall", 32'(bus.o_stall), 32'd0);
        nxt(); drv(1, 7, 1, 0, 1, 1, 0, OP_ADD, 0);
        smp(); chk("byp_c1_wbv", 32'(bus.o_wb_valid), 32'd1);
               chk("byp_c1_wbs", 32'(bus.o_wb_sel), 32'd1);
               chk("byp_c1_issue", 32'(bus.o_issue), 32'd1);
        nxt(); idle();
        smp(); chk("byp_c2_wbv", 32'(bus.o_wb_valid), 32'd1);
               chk("byp_c2_wbs", 32'(bus.o_wb_sel), 32'd7);
        nxt();
        smp(); chk("byp_c3_wbv", 32'(bus.o_wb_valid), 32'd0);
        nxt();

        // ---- load-use stall
        do_reset("lw");
        drv(1, 2, 0, 0, 0, 1, 1, OP_ADD, 0);
        smp(); chk("lw_c0_issue", 32'(bus.o_issue), 32'd1);
        nxt(); drv(1, 3, 2, 0, 0, 1, 0, OP_ADD, 0);
        smp(); chk("lw_c1_stall", 32'(bus.o_stall), 32'd1);
               chk("lw_c1_issue", 32'(bus.o_issue), 32'd0);
               chk("lw_c1_wbv", 32'(bus.o_wb_valid), 32'd0);
        nxt();
        smp(); chk("lw_c2_issue", 32'(bus.o_issue), 32'd1);
               chk("lw_c2_stall", 32'(bus.o_stall), 32'd0);
               chk("lw_c2_wbs", 32'(bus.o_wb_sel), 32'd2);
               chk("lw_c2_wbv", 32'(bus.o_wb_valid), 32'd1);
        nxt(); idle();
        smp(); chk("lw_c3_cnt", 32'(bus.o_stall_count), 32'd1);
               chk("lw_c3_wbs", 32'(bus.o_wb_sel), 32'd3);
        nxt();

        // ---- MUL then independent ADD: writeback slot conflict
        do_reset("mul");
        drv(1, 3, 0, 0, 0, 1, 0, OP_MUL, 0);
        smp(); chk("mul_c0_issue", 32'(bus.o_issue), 32'd1);
        nxt(); idle();
        nxt(); drv(1, 4, 1, 0, 0, 1, 0, OP_ADD, 0);
        smp(); chk("mul_c2_stall", 32'(bus.o_stall), 32'd1);
               chk("mul_c2_issue", 32'(bus.o_issue), 32'd0);
        nxt();
        smp(); chk("mul_c3_issue", 32'(bus.o_issue), 32'd1);
               chk("mul_c3_wbv", 32'(bus.o_wb_valid), 32'd1);
               chk("mul_c3_wbs", 32'(bus.o_wb_sel), 32'd3);
        nxt(); idle();
        smp(); chk("mul_c4_wbv", 32'(bus.o_wb_valid), 32'd1);
               chk("mul_c4_wbs", 32'(bus.o_wb_sel), 32'd4);
        nxt();

        // ---- back-to-back DIV: divider occupancy
        do_reset("div");
        drv(1, 5, 0, 0, 0, 1, 0, OP_DIV, 0);
        smp(); chk("div_c0_issue", 32'(bus.o_issue), 32'd1);
               chk("div_c0_busy", 32'(bus.o_div_busy), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            nxt(); drv(1, 6, 0, 0, 0, 1, 0, OP_DIV, 0);
            smp(); chk($sformatf("div_c%0d_busy", c), 32'(bus.o_div_busy), 32'd1);
                   chk($sformatf("div_c%0d_stall", c), 32'(bus.o_stall), 32'd1);
        end
        nxt();
        smp(); chk("div_c6_issue", 32'(bus.o_issue), 32'd1);
               chk("div_c6_busy", 32'(bus.o_div_busy), 32'd0);
               chk("div_c6_wbv", 32'(bus.o_wb_valid), 32'd1);
               chk("div_c6_wbs", 32'(bus.o_wb_sel), 32'd5);
        nxt(); idle();
        smp(); chk("div_c7_busy", 32'(bus.o_div_busy), 32'd1);
        for (int c = 7; c <= 11; c++) begin
            if (c > 7) begin
                nxt();
                smp();
            end
            chk($sformatf("div_c%0d_wbv", c), 32'(bus.o_wb_valid), 32'd0);
        end
        nxt();
        smp(); chk("div_c12_wbv", 32'(bus.o_wb_valid), 32'd1);
               chk("div_c12_wbs", 32'(bus.o_wb_sel), 32'd6);
               chk("div_c12_cnt", 32'(bus.o_stall_count), 32'd5);
        nxt();
        do_reset("divcnt");

        // ---- divider busy dropped by reset
        drv(1, 5, 0, 0, 0, 1, 0, OP_DIV, 0);
        smp(); chk("divr_c0_issue", 32'(bus.o_issue), 32'd1);
        nxt(); idle();
        smp(); chk("divr_c1_busy", 32'(bus.o_div_busy), 32'd1);
        nxt();
        do_reset("divr");

        // ---- reset during an in-flight MUL
        drv(1, 3, 0, 0, 0, 1, 0, OP_MUL, 0);
        smp(); chk("rmul_c0_issue", 32'(bus.o_issue), 32'd1);
        nxt(); idle(); rst_n = 1'b0;
        #1;    chk("rmul_c1_wbv", 32'(bus.o_wb_valid), 32'd0);
        nxt(); rst_n = 1'b1;
        smp(); chk("rmul_c2_wbv", 32'(bus.o_wb_valid), 32'd0);
        nxt(); drv(1, 3, 3, 0, 0, 1, 0, OP_ADD, 0);
        smp(); chk("rmul_c3_wbv", 32'(bus.o_wb_valid), 32'd0);
               chk("rmul_c3_issue", 32'(bus.o_issue), 32'd1);
               chk("rmul_c3_stall", 32'(bus.o_stall), 32'd0);
        nxt(); idle();
        smp(); chk("rmul_c4_wbv", 32'(bus.o_wb_valid), 32'd1);
               chk("rmul_c4_wbs", 32'(bus.o_wb_sel), 32'd3);
        nxt();

        // ---- reset asserted while a writeback strobe is showing
        drv(1, 1, 0, 0, 0, 1, 0, OP_ADD, 0);
        nxt(); idle();
        smp(); chk("async_pre_wbv", 32'(bus.o_wb_valid), 32'd1);
               chk("async_pre_wbs", 32'(bus.o_wb_sel), 32'd1);
        #1 rst_n = 1'b0;
        #1;    chk("async_wbv", 32'(bus.o_wb_valid), 32'd0);
               chk("async_wbs", 32'(bus.o_wb_sel), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- flush blocks only the current instruction
        drv(1, 2, 0, 0, 0, 1, 0, OP_MUL, 0);
        smp(); chk("fl_c0_issue", 32'(bus.o_issue), 32'd1);
        nxt(); drv(1, 1, 0, 0, 0, 1, 0, OP_ADD, 1);
        smp(); chk("fl_c1_issue", 32'(bus.o_issue), 32'd0);
               chk("fl_c1_stall", 32'(bus.o_stall), 32'd0);
        nxt(); idle();
        smp(); chk("fl_c2_wbv", 32'(bus.o_wb_valid), 32'd0);
        nxt();
        smp(); chk("fl_c3_wbv", 32'(bus.o_wb_valid), 32'd1);
               chk("fl_c3_wbs", 32'(bus.o_wb_sel), 32'd2);
               chk("fl_c3_cnt", 32'(bus.o_stall_count), 32'd0);
        nxt();

        // ---- unused rs2 and non-writing instructions
        drv(1, 2, 0, 0, 0, 1, 0, OP_MUL, 0);
        nxt(); drv(1, 1, 0, 2, 0, 1, 0, OP_ADD, 0);
        smp(); chk("rs2_c1_issue", 32'(bus.o_issue), 32'd1);
               chk("rs2_c1_stall", 32'(bus.o_stall), 32'd0);
        nxt(); drv(1, 3, 0, 2, 1, 1, 0, OP_ADD, 0);
        smp(); chk("rs2_c2_stall", 32'(bus.o_stall), 32'd1);
               chk("rs2_c2_wbs", 32'(bus.o_wb_sel), 32'd1);
        nxt();
        smp(); chk("rs2_c3_issue", 32'(bus.o_issue), 32'd1);
               chk("rs2_c3_wbs", 32'(bus.o_wb_sel), 32'd2);
        nxt(); drv(1, 6, 0, 0, 0, 1, 0, OP_MUL, 0);
        smp(); chk("st_c4_issue", 32'(bus.o_issue), 32'd1);
               chk("st_c4_wbs", 32'(bus.o_wb_sel), 32'd3);
        nxt(); drv(1, 6, 0, 0, 0, 0, 0, OP_ADD, 0);
        smp(); chk("st_c5_issue", 32'(bus.o_issue), 32'd1);
               chk("st_c5_wbv", 32'(bus.o_wb_valid), 32'd0);
        nxt(); idle();
        smp(); chk("st_c6_wbv", 32'(bus.o_wb_valid), 32'd0);
               chk("st_c6_cnt", 32'(bus.o_stall_count), 32'd1);
        nxt();
        smp(); chk("st_c7_wbv", 32'(bus.o_wb_valid), 32'd1);
               chk("st_c7_wbs", 32'(bus.o_wb_sel), 32'd6);
        nxt();

        // ---- stall counter saturation: a DIV every 6 cycles, 5 stalls each
        do_reset("sat");
        drv(1, 5, 0, 0, 0, 1, 0, OP_DIV, 0);
        repeat (6 * 13106) @(posedge clk);
        #1;
        smp(); chk("sat_pre_cnt", 32'(bus.o_stall_count), 32'h0000FFFA);
               chk("sat_pre_issue", 32'(bus.o_issue), 32'd1);
        repeat (6) @(posedge clk);
        smp(); chk("sat_max_cnt", 32'(bus.o_stall_count), 32'h0000FFFF);
        repeat (6) @(posedge clk);
        smp(); chk("sat_hold_cnt", 32'(bus.o_stall_count), 32'h0000FFFF);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
